// File: rtl/ctx_pkg.sv
// ctx_pkg: shared definitions for the JPEG-LS / LOCO-I causal-neighbourhood
// generator (ctx_window_gen) and its line buffer.
//   PIX_W_DEF / IMG_W_DEF / IMG_H_DEF : default sample width and frame size
//   ctx_t                             : one context {ix, ra, rb, rc, rd} at default width
//   clog2_min1                        : ceil(log2(n)) clamped to at least 1, so that
//                                       single-line frames still get a 1-bit row counter
package ctx_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int IMG_W_DEF = 512;
  localparam int IMG_H_DEF = 512;

  typedef struct packed {
    logic [PIX_W_DEF-1:0] ix;
    logic [PIX_W_DEF-1:0] ra;
    logic [PIX_W_DEF-1:0] rb;
    logic [PIX_W_DEF-1:0] rc;
    logic [PIX_W_DEF-1:0] rd;
  } ctx_t;

  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ctx_line_buf.sv
// ctx_line_buf: one-line sample store for ctx_window_gen.
// Simple dual-port RAM, DEPTH x PIX_W, one write port and one synchronous
// read port. A read of any address in the same cycle as a write returns the
// previously stored data. rd_data only updates when rd_en is high, so the
// prefetched word is held across stalls.
//   clk, reset            : clock, asynchronous active-low reset (rd_data only)
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr         : read request
//   rd_data               : registered read data
module ctx_line_buf
  import ctx_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int DEPTH  = IMG_W_DEF,
  parameter int ADDR_W = clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data
);

  logic [PIX_W-1:0] mem_r [DEPTH];

  // Storage array write; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read; holds its value when no read is requested.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= {PIX_W{1'b0}};
    end else if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/ctx_window_gen.sv
// ctx_window_gen: JPEG-LS / LOCO-I causal-neighbourhood generator.
// Accepts a raster pixel stream and emits each sample ix with its neighbours
// ra (left), rb (above), rc (above-left), rd (above-right), applying the
// standard edge rules, plus position and line/frame boundary flags.
// One cycle latency, one pixel per clock with valid/ready flow control.
// Optional build macro CTX_GRAD_EN adds signed local gradients d1/d2/d3.
//   clk, reset                      : clock, asynchronous active-low reset
//   in_valid/in_ready/in_sof/in_pix : input stream (in_sof restarts at (0,0))
//   out_valid/out_ready             : output handshake
//   ix, ra, rb, rc, rd              : current sample and neighbours
//   col, row, sol, eol, eof         : position of ix and boundary flags
//   d1, d2, d3 (CTX_GRAD_EN only)   : rd-rb, rb-rc, rc-ra
module ctx_window_gen
  import ctx_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int COL_W = clog2_min1(IMG_W),
  parameter int ROW_W = clog2_min1(IMG_H)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sof,
  input  logic [PIX_W-1:0]        in_pix,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PIX_W-1:0]        ix,
  output logic [PIX_W-1:0]        ra,
  output logic [PIX_W-1:0]        rb,
  output logic [PIX_W-1:0]        rc,
  output logic [PIX_W-1:0]        rd,
  output logic [COL_W-1:0]        col,
  output logic [ROW_W-1:0]        row,
`ifdef CTX_GRAD_EN
  output logic signed [PIX_W:0]   d1,
  output logic signed [PIX_W:0]   d2,
  output logic signed [PIX_W:0]   d3,
`endif
  output logic                    sol,
  output logic                    eol,
  output logic                    eof
);

  localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [PIX_W-1:0] PIX_ZERO = {PIX_W{1'b0}};
  // With two columns the prefetch of column 1 would collide with the write of
  // column 1; the previous sample is that very pixel, so it is used instead.
  localparam bit NARROW = (IMG_W == 2);

  logic             accept_s;
  logic [COL_W-1:0] col_r, cur_col_s, nxt_col_s, rd_addr_s;
  logic [ROW_W-1:0] row_r, cur_row_s, nxt_row_s;
  logic [PIX_W-1:0] prev_pix_r;   // last accepted sample (ra inside a line)
  logic [PIX_W-1:0] line0_r;      // pixel(r-1,0): ra/rb at column 0
  logic [PIX_W-1:0] line0_prev_r; // pixel(r-2,0): rc at column 0
  logic [PIX_W-1:0] above_b_r;    // pixel(r-1,c) for the next sample
  logic [PIX_W-1:0] above_c_r;    // pixel(r-1,c-1) for the next sample
  logic [PIX_W-1:0] buf_rdata_s;  // prefetched pixel(r-1,c+1)
  logic [PIX_W-1:0] ra_s, rb_s, rc_s, rd_s;

  assign in_ready = !out_valid || out_ready;
  assign accept_s = in_valid && in_ready;

  ctx_line_buf #(
    .PIX_W  (PIX_W),
    .DEPTH  (IMG_W),
    .ADDR_W (COL_W)
  ) u_line_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept_s),
    .wr_addr (cur_col_s),
    .wr_data (in_pix),
    .rd_en   (accept_s),
    .rd_addr (rd_addr_s),
    .rd_data (buf_rdata_s)
  );

  // Position of the offered sample, the position after it, and the prefetch address.
  always_comb begin
    cur_col_s = col_r;
    cur_row_s = row_r;
    nxt_col_s = COL_ZERO;
    nxt_row_s = ROW_ZERO;
    rd_addr_s = COL_ZERO;
    if (in_sof) begin
      cur_col_s = COL_ZERO;
      cur_row_s = ROW_ZERO;
    end else begin
      cur_col_s = col_r;
      cur_row_s = row_r;
    end
    if (cur_col_s == COL_LAST) begin
      nxt_col_s = COL_ZERO;
      if (cur_row_s == ROW_LAST) begin
        nxt_row_s = ROW_ZERO;
      end else begin
        nxt_row_s = cur_row_s + ROW_ONE;
      end
    end else begin
      nxt_col_s = cur_col_s + COL_ONE;
      nxt_row_s = cur_row_s;
    end
    // The next sample needs pixel(r-1, next_col+1); the last column uses rb instead.
    if (nxt_col_s == COL_LAST) begin
      rd_addr_s = COL_ZERO;
    end else begin
      rd_addr_s = nxt_col_s + COL_ONE;
    end
  end

  // Neighbour selection with the edge rules for the offered sample.
  always_comb begin
    ra_s = PIX_ZERO;
    rb_s = PIX_ZERO;
    rc_s = PIX_ZERO;
    rd_s = PIX_ZERO;
    if (cur_row_s == ROW_ZERO) begin
      if (cur_col_s == COL_ZERO) begin
        ra_s = PIX_ZERO;
      end else begin
        ra_s = prev_pix_r;
      end
    end else if (cur_col_s == COL_ZERO) begin
      ra_s = line0_r;
      rb_s = line0_r;
      rc_s = line0_prev_r;
      if (NARROW) begin
        rd_s = prev_pix_r;
      end else begin
        rd_s = buf_rdata_s;
      end
    end else begin
      ra_s = prev_pix_r;
      rb_s = above_b_r;
      rc_s = above_c_r;
      if (cur_col_s == COL_LAST) begin
        rd_s = above_b_r;
      end else begin
        rd_s = buf_rdata_s;
      end
    end
  end

  // Position counters and saved edge samples, advanced only on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_r        <= COL_ZERO;
      row_r        <= ROW_ZERO;
      prev_pix_r   <= PIX_ZERO;
      line0_r      <= PIX_ZERO;
      line0_prev_r <= PIX_ZERO;
      above_b_r    <= PIX_ZERO;
      above_c_r    <= PIX_ZERO;
    end else if (accept_s) begin
      col_r      <= nxt_col_s;
      row_r      <= nxt_row_s;
      prev_pix_r <= in_pix;
      // Slide the above-row window one column right.
      above_c_r  <= rb_s;
      above_b_r  <= rd_s;
      if (cur_col_s == COL_ZERO) begin
        line0_r <= in_pix;
        // rc of row 1 column 0 is 0, so the first line seeds it with 0.
        if (cur_row_s == ROW_ZERO) begin
          line0_prev_r <= PIX_ZERO;
        end else begin
          line0_prev_r <= line0_r;
        end
      end
    end
  end

  // Output context register; holds while the downstream stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      ix        <= PIX_ZERO;
      ra        <= PIX_ZERO;
      rb        <= PIX_ZERO;
      rc        <= PIX_ZERO;
      rd        <= PIX_ZERO;
      col       <= COL_ZERO;
      row       <= ROW_ZERO;
      sol       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
    end else if (accept_s) begin
      out_valid <= 1'b1;
      ix        <= in_pix;
      ra        <= ra_s;
      rb        <= rb_s;
      rc        <= rc_s;
      rd        <= rd_s;
      col       <= cur_col_s;
      row       <= cur_row_s;
      sol       <= (cur_col_s == COL_ZERO);
      eol       <= (cur_col_s == COL_LAST);
      eof       <= (cur_col_s == COL_LAST) && (cur_row_s == ROW_LAST);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef CTX_GRAD_EN
  // Local gradients, registered alongside ix.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d1 <= {(PIX_W+1){1'b0}};
      d2 <= {(PIX_W+1){1'b0}};
      d3 <= {(PIX_W+1){1'b0}};
    end else if (accept_s) begin
      d1 <= $signed({1'b0, rd_s}) - $signed({1'b0, rb_s});
      d2 <= $signed({1'b0, rb_s}) - $signed({1'b0, rc_s});
      d3 <= $signed({1'b0, rc_s}) - $signed({1'b0, ra_s});
    end
  end
`endif

endmodule
